cpu_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 9-bit CPU. Owns the PC and a return-address stack, and fetches words from instruction memory over a req/ack handshake.
- Presents each instruction to the combinational decoder. Stalls on data-memory load/store handshakes and produces the per-instruction execute strobe for the datapath.
- Sits between instruction memory, the decoder, the register file/ALU and data memory.

---
 rtl/instr_pack.sv | 17 +
 rtl/ret_stack.sv | 48 ++++
 rtl/cpu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pack.sv
// Shared types and defaults for the 9-bit CPU sequencer.
package instr_pack;

    localparam int PC_W_DEF        = 10;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int INSTR_W         = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4,
        FAULT = 3'd5
    } seq_state;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack with full/empty flags; guarded push/pop and synchronous clear.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign sp_dec = sp - SP_W'(1);
    assign top    = mem[sp_dec[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Entry storage carries no reset; only sp decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC, instruction latch and return stack,
// and handshakes with instruction and data memory.
module cpu_sequencer
    import instr_pack::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               exec_en,
    input  logic               done_i,
    input  logic               jump2sub_i,
    input  logic               ret_i,
    input  logic               loadEn_i,
    input  logic               storEn_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic [PC_W-1:0]    jsr_target_i,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    seq_state           state;
    seq_state           state_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_load;
    logic               push;
    logic               pop;
    logic               stack_clear;
    logic               stack_full;
    logic               stack_empty;
    logic [PC_W-1:0]    stack_top;

    assign pc_inc = pc + PC_W'(1);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (stack_clear),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            instr_q <= '0;
        end else begin
            pc <= pc_next;
            if (instr_load) begin
                instr_q <= imem_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: if (imem_ack) state_next = EXEC;
            EXEC: begin
                if (done_i)                      state_next = HALT;
                else if (jump2sub_i)             state_next = stack_full ? FAULT : FETCH;
                else if (ret_i)                  state_next = stack_empty ? FAULT : FETCH;
                else if (loadEn_i || storEn_i)   state_next = dmem_ack ? FETCH : MEM;
                else                             state_next = FETCH;
            end
            MEM:   if (dmem_ack) state_next = FETCH;
            HALT:  if (start) state_next = FETCH;
            FAULT: state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // Commit strobe, stack ops and PC update are decided from the same priority chain.
    always_comb begin
        exec_en     = 1'b0;
        dmem_req    = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        stack_clear = 1'b0;
        instr_load  = 1'b0;
        pc_next     = pc;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    stack_clear = 1'b1;
                    pc_next     = '0;
                end
            end
            FETCH: instr_load = imem_ack;
            EXEC: begin
                if (done_i) begin
                    pc_next = pc;
                end else if (jump2sub_i) begin
                    if (!stack_full) begin
                        push    = 1'b1;
                        pc_next = jsr_target_i;
                        exec_en = 1'b1;
                    end
                end else if (ret_i) begin
                    if (!stack_empty) begin
                        pop     = 1'b1;
                        pc_next = stack_top;
                        exec_en = 1'b1;
                    end
                end else if (loadEn_i || storEn_i) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        exec_en = 1'b1;
                        pc_next = pc_inc;
                    end
                end else if (branch_taken_i) begin
                    pc_next = branch_target_i;
                    exec_en = 1'b1;
                end else begin
                    pc_next = pc_inc;
                    exec_en = 1'b1;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    exec_en = 1'b1;
                    pc_next = pc_inc;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign instr     = instr_q;
    assign busy      = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign done      = (state == HALT);
    assign fault     = (state == FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a per-cycle vector table plus hand-written corner sequences.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_data;
    logic [8:0] instr;
    logic       exec_en;
    logic       done_i, jump2sub_i, ret_i, loadEn_i, storEn_i, branch_taken_i;
    logic [9:0] branch_target_i, jsr_target_i;
    logic       dmem_req, dmem_ack;
    logic       busy, done, fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(10), .STACK_DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .instr           (instr),
        .exec_en         (exec_en),
        .done_i          (done_i),
        .jump2sub_i      (jump2sub_i),
        .ret_i           (ret_i),
        .loadEn_i        (loadEn_i),
        .storEn_i        (storEn_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jsr_target_i    (jsr_target_i),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .busy            (busy),
        .done            (done),
        .fault           (fault)
    );

    typedef struct {
        logic       start, iack;
        logic [8:0] idata;
        logic       dn, jsr, ret, ld, st, br;
        logic [9:0] btgt, jtgt;
        logic       dack;
        logic       e_ireq;
        logic [9:0] e_iaddr;
        logic       e_exec, e_dreq, e_busy, e_done, e_fault;
        logic [8:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] dword(input int a);
        return 9'(a) ^ 9'h0A5;
    endfunction

    function automatic vec_t blank();
        vec_t x;
        x.start = 0; x.iack = 0; x.idata = '0; x.dn = 0; x.jsr = 0; x.ret = 0;
        x.ld = 0; x.st = 0; x.br = 0; x.btgt = '0; x.jtgt = '0; x.dack = 0;
        x.e_ireq = 0; x.e_iaddr = '0; x.e_exec = 0; x.e_dreq = 0; x.e_busy = 0;
        x.e_done = 0; x.e_fault = 0; x.e_instr = '0;
        return x;
    endfunction

    function automatic vec_t fetch_v(input int addr, input logic ack, input logic [8:0] cur);
        vec_t x = blank();
        x.iack = ack; x.idata = dword(addr);
        x.e_ireq = 1; x.e_iaddr = 10'(addr); x.e_busy = 1; x.e_instr = cur;
        return x;
    endfunction

    function automatic vec_t exec_v(input int addr, input logic [8:0] cur);
        vec_t x = blank();
        x.e_iaddr = 10'(addr); x.e_busy = 1; x.e_exec = 1; x.e_instr = cur;
        return x;
    endfunction

    function automatic vec_t halt_v(input int addr, input logic [8:0] cur);
        vec_t x = blank();
        x.e_iaddr = 10'(addr); x.e_done = 1; x.e_instr = cur;
        return x;
    endfunction

    function automatic logic [31:0] outs();
        return {7'b0, imem_req, imem_addr, exec_en, dmem_req, busy, done, fault, instr};
    endfunction

    function automatic logic [31:0] exp_of(input vec_t x);
        return {7'b0, x.e_ireq, x.e_iaddr, x.e_exec, x.e_dreq, x.e_busy, x.e_done, x.e_fault, x.e_instr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        start = 0; imem_ack = 0; imem_data = '0; done_i = 0; jump2sub_i = 0; ret_i = 0;
        loadEn_i = 0; storEn_i = 0; branch_taken_i = 0; branch_target_i = '0;
        jsr_target_i = '0; dmem_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic start_run();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic fetch_one(input int addr);
        imem_ack = 1;
        imem_data = dword(addr);
        @(negedge clk);
        check($sformatf("fetch_addr_%0d", addr), 32'(imem_addr), 32'(addr));
        step();
        imem_ack = 0;
    endtask

    task automatic build_table();
        vec_t x;
        logic [8:0] cur = '0;
        tbl.push_back(blank());
        x = blank(); x.start = 1; x.iack = 1; x.dack = 1; tbl.push_back(x);
        for (int a = 0; a < 5; a++) begin
            tbl.push_back(fetch_v(a, 1, cur)); cur = dword(a);
            tbl.push_back(exec_v(a, cur));
        end
        // Three-cycle fetch stall at 5, with a start pulse that must be ignored.
        x = fetch_v(5, 0, cur); tbl.push_back(x);
        x.start = 1; tbl.push_back(x);
        x.start = 0; tbl.push_back(x);
        tbl.push_back(fetch_v(5, 1, cur)); cur = dword(5);
        tbl.push_back(exec_v(5, cur));
        // Load at 6 waits four cycles for dmem_ack.
        tbl.push_back(fetch_v(6, 1, cur)); cur = dword(6);
        x = exec_v(6, cur); x.ld = 1; x.e_exec = 0; x.e_dreq = 1; tbl.push_back(x);
        x = exec_v(6, cur); x.e_exec = 0; x.e_dreq = 1; tbl.push_back(x);
        x.iack = 1; tbl.push_back(x);
        x.iack = 0; tbl.push_back(x);
        x = exec_v(6, cur); x.e_dreq = 1; x.dack = 1; tbl.push_back(x);
        // jsr at 7 to 40, ret (with load also asserted) back to 8.
        tbl.push_back(fetch_v(7, 1, cur)); cur = dword(7);
        x = exec_v(7, cur); x.jsr = 1; x.jtgt = 10'd40; tbl.push_back(x);
        tbl.push_back(fetch_v(40, 1, cur)); cur = dword(40);
        x = exec_v(40, cur); x.ret = 1; x.ld = 1; tbl.push_back(x);
        // Store at 8 with same-cycle ack outranks the branch request.
        tbl.push_back(fetch_v(8, 1, cur)); cur = dword(8);
        x = exec_v(8, cur); x.st = 1; x.dack = 1; x.br = 1; x.btgt = 10'd200; x.e_dreq = 1; tbl.push_back(x);
        tbl.push_back(fetch_v(9, 1, cur)); cur = dword(9);
        x = exec_v(9, cur); x.br = 1; x.btgt = 10'd12; tbl.push_back(x);
        tbl.push_back(fetch_v(12, 1, cur)); cur = dword(12);
        x = exec_v(12, cur); x.dn = 1; x.jsr = 1; x.jtgt = 10'd300; x.e_exec = 0; tbl.push_back(x);
        x = halt_v(12, cur); x.iack = 1; x.dack = 1; tbl.push_back(x);
        x = halt_v(12, cur); x.start = 1; tbl.push_back(x);
        // Restart at 0, then wrap from the top address back to 0.
        tbl.push_back(fetch_v(0, 1, cur)); cur = dword(0);
        x = exec_v(0, cur); x.br = 1; x.btgt = 10'd1023; tbl.push_back(x);
        tbl.push_back(fetch_v(1023, 1, cur)); cur = dword(1023);
        tbl.push_back(exec_v(1023, cur));
        tbl.push_back(fetch_v(0, 0, cur));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        reset_n = 0;
        #1;
        check("reset_outputs", outs(), 32'h0);
        step();
        reset_n = 1;

        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; imem_ack = tbl[i].iack; imem_data = tbl[i].idata;
            done_i = tbl[i].dn; jump2sub_i = tbl[i].jsr; ret_i = tbl[i].ret;
            loadEn_i = tbl[i].ld; storEn_i = tbl[i].st; branch_taken_i = tbl[i].br;
            branch_target_i = tbl[i].btgt; jsr_target_i = tbl[i].jtgt; dmem_ack = tbl[i].dack;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), exp_of(tbl[i]));
            step();
        end
        clr_in();

        // Fifth nested jsr overflows a 4-entry stack.
        do_reset();
        start_run();
        for (int k = 0; k < 5; k++) begin
            fetch_one(k == 0 ? 0 : 100 + 10 * (k - 1));
            jump2sub_i = 1;
            jsr_target_i = 10'(100 + 10 * k);
            @(negedge clk);
            check($sformatf("ovf_exec_%0d", k), 32'(exec_en), (k < 4) ? 32'd1 : 32'd0);
            step();
            jump2sub_i = 0;
        end
        @(negedge clk);
        check("ovf_fault", {28'b0, fault, busy, imem_req, exec_en}, 32'h8);
        start = 1;
        step();
        start = 0;
        @(negedge clk);
        check("ovf_sticky", {21'b0, fault, imem_req, imem_addr}, {21'b0, 1'b1, 1'b0, 10'd130});

        // Return with an empty stack straight after reset.
        do_reset();
        start_run();
        fetch_one(0);
        ret_i = 1;
        @(negedge clk);
        check("unf_exec", 32'(exec_en), 32'd0);
        step();
        ret_i = 0;
        @(negedge clk);
        check("unf_fault", {30'b0, fault, busy}, 32'h2);

        // jsr then ret leaves the stack empty: a second ret faults.
        do_reset();
        start_run();
        fetch_one(0);
        jump2sub_i = 1; jsr_target_i = 10'd40;
        step();
        jump2sub_i = 0;
        fetch_one(40);
        ret_i = 1;
        @(negedge clk);
        check("pair_ret_exec", 32'(exec_en), 32'd1);
        step();
        ret_i = 0;
        fetch_one(1);
        ret_i = 1;
        @(negedge clk);
        check("pair_ret2_exec", 32'(exec_en), 32'd0);
        step();
        ret_i = 0;
        @(negedge clk);
        check("pair_fault", 32'(fault), 32'd1);

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        start_run();
        fetch_one(0);
        loadEn_i = 1;
        step();
        loadEn_i = 0;
        @(negedge clk);
        check("mem_wait", {30'b0, dmem_req, busy}, 32'h3);
        #2;
        reset_n = 0;
        dmem_ack = 1;
        #1;
        check("mem_async_reset", outs(), 32'h0);
        dmem_ack = 0;
        step();
        reset_n = 1;
        @(negedge clk);
        check("post_reset_idle", outs(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
